// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register write-reservation tracker for the 5-stage pipeline. Decode reserves
// the destination of every register-writing instruction as it issues into EX;
// writeback releases it when the value lands in the register file. Each
// register keeps a small count of in-flight writers so that several
// outstanding writes to the same register are tracked correctly.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          asynchronous, active-low; clears all state
//   issue_valid    decode presents an instruction this cycle
//   issue_rs/rt    source register indices (rt doubles as dst when regDstD=0)
//   use_rs/use_rt  instruction actually reads rs / rt
//   regWriteD      instruction writes a register
//   regDstD        destination select: 0 -> issue_rt, 1 -> RdD
//   RdD            rd field
//   regWriteW      writeback commits this cycle
//   indexWB        writeback destination index
//   flush          squash: drop every reservation at the next edge
//   stall          decode must hold; the instruction is not issued
//   rs_ready       issue_rs has no pending writer (same-cycle WB counts as done)
//   rt_ready       issue_rt has no pending writer (same-cycle WB counts as done)
//   busy_vec       registered view, bit n = register n has a pending writer
//   err_underflow  sticky: a release arrived for a register with no writer
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2,
  parameter int FMASK = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic            use_rs,
  input  logic            use_rt,
  input  logic            regWriteD,
  input  logic            regDstD,
  input  logic [AW-1:0]   RdD,
  input  logic            regWriteW,
  input  logic [AW-1:0]   indexWB,
  input  logic            flush,
  output logic            stall,
  output logic            rs_ready,
  output logic            rt_ready,
  output logic [NREG-1:0] busy_vec,
  output logic            err_underflow
);

  localparam logic [CNT_W-1:0] MAXCNT  = '1;
  localparam int               FW      = (FMASK > 0) ? $clog2(FMASK + 1) : 1;
  localparam logic [FW-1:0]    FMASK_V = FW'(FMASK);

  logic [CNT_W-1:0] cnt [NREG];
  logic [FW-1:0]    fmaskCnt;

  logic [AW-1:0]    dst;
  logic             relHit;
  logic             underflowHit;
  logic             dstFull;
  logic             res;
  logic [CNT_W-1:0] effRs;
  logic [CNT_W-1:0] effRt;
  logic [NREG-1:0]  incVec;
  logic [NREG-1:0]  decVec;

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the comb logic can leave one unassigned and infer a latch.
  always_comb begin
    dst          = regDstD ? RdD : issue_rt;
    relHit       = regWriteW && (indexWB != '0) && (cnt[indexWB] != '0);
    underflowHit = regWriteW && (indexWB != '0) && (cnt[indexWB] == '0);

    // A writer retiring this very cycle no longer blocks its readers.
    effRs    = cnt[issue_rs] - CNT_W'(relHit && (indexWB == issue_rs));
    effRt    = cnt[issue_rt] - CNT_W'(relHit && (indexWB == issue_rt));
    rs_ready = (issue_rs == '0) || (effRs == '0);
    rt_ready = (issue_rt == '0) || (effRt == '0);

    // Saturated destination counter: issuing would wrap it, unless a release
    // of the same register frees a slot in this cycle.
    dstFull = regWriteD && (dst != '0) && (cnt[dst] == MAXCNT) &&
              !(relHit && (indexWB == dst));

    stall = issue_valid && !flush &&
            ((use_rs && !rs_ready) || (use_rt && !rt_ready) || dstFull);
    res   = issue_valid && !stall && !flush && regWriteD && (dst != '0);

    incVec = '0;
    decVec = '0;
    if (res)    incVec[dst]     = 1'b1;
    if (relHit) decVec[indexWB] = 1'b1;

    busy_vec = '0;
    for (int n = 0; n < NREG; n++) busy_vec[n] = (cnt[n] != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counter array is cleared by reset on purpose: a stale
      // reservation would stall decode forever, so it is control state, not
      // data storage, and is kept in flops.
      for (int n = 0; n < NREG; n++) cnt[n] <= '0;
      fmaskCnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int n = 0; n < NREG; n++) begin
        if (flush || n == 0) begin
          cnt[n] <= '0;
        end else if (incVec[n] && !decVec[n]) begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end else if (decVec[n] && !incVec[n]) begin
          cnt[n] <= cnt[n] - CNT_W'(1);
        end
      end

      // After a flush, late writebacks from the squashed path may legally
      // hit already-cleared counters; keep them quiet for FMASK cycles.
      if (flush) begin
        fmaskCnt <= FMASK_V;
      end else if (fmaskCnt != '0) begin
        fmaskCnt <= fmaskCnt - FW'(1);
      end

      if (underflowHit && (fmaskCnt == '0)) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Scoreboard bench. The stimulus process drives one cycle of inputs, asks a
// behavioural model (integer writer counts per register) for the expected
// outputs of that cycle, and pushes them into a queue. An independent monitor
// samples the DUT mid-cycle and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int MAXW  = 3;
  localparam int FMASK = 3;

  typedef struct {
    bit rstLow;
    bit issueValid;
    int rs;
    int rt;
    bit useRs;
    bit useRt;
    bit regWriteD;
    bit regDstD;
    int rd;
    bit regWriteW;
    int idx;
    bit flush;
  } stim_t;

  typedef struct {
    bit          stall;
    bit          rsReady;
    bit          rtReady;
    bit          err;
    logic [31:0] busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            issue_valid = 1'b0;
  logic [AW-1:0]   issue_rs = '0;
  logic [AW-1:0]   issue_rt = '0;
  logic            use_rs = 1'b0;
  logic            use_rt = 1'b0;
  logic            regWriteD = 1'b0;
  logic            regDstD = 1'b0;
  logic [AW-1:0]   RdD = '0;
  logic            regWriteW = 1'b0;
  logic [AW-1:0]   indexWB = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic            rs_ready;
  logic            rt_ready;
  logic [NREG-1:0] busy_vec;
  logic            err_underflow;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .CNT_W(2), .FMASK(FMASK)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .regWriteD    (regWriteD),
    .regDstD      (regDstD),
    .RdD          (RdD),
    .regWriteW    (regWriteW),
    .indexWB      (indexWB),
    .flush        (flush),
    .stall        (stall),
    .rs_ready     (rs_ready),
    .rt_ready     (rt_ready),
    .busy_vec     (busy_vec),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending writers per register, mask timer, sticky flag.
  int   mcnt [NREG];
  int   mfmask;
  bit   merr;
  exp_t expQ [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s = '{default: 0};
    s.rstLow = 1'b0;
    return s;
  endfunction

  function automatic bit freeAfterWb(input int r, input bit rel, input int idx);
    int pending;
    if (r == 0) return 1'b1;
    pending = mcnt[r] - ((rel && idx == r) ? 1 : 0);
    return pending == 0;
  endfunction

  // One clock cycle: drive, predict, enqueue, advance the model past the edge.
  task automatic cyc(input stim_t s);
    exp_t e;
    int   dst;
    bit   rel;
    bit   res;
    bit   full;
    @(negedge clk);
    if (!s.rstLow) reset = 1'b1;
    issue_valid = s.issueValid;
    issue_rs    = AW'(s.rs);
    issue_rt    = AW'(s.rt);
    use_rs      = s.useRs;
    use_rt      = s.useRt;
    regWriteD   = s.regWriteD;
    regDstD     = s.regDstD;
    RdD         = AW'(s.rd);
    regWriteW   = s.regWriteW;
    indexWB     = AW'(s.idx);
    flush       = s.flush;

    if (s.rstLow) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mfmask = 0;
      merr   = 1'b0;
    end

    dst       = s.regDstD ? s.rd : s.rt;
    rel       = s.regWriteW && s.idx != 0 && mcnt[s.idx] > 0;
    e.rsReady = freeAfterWb(s.rs, rel, s.idx);
    e.rtReady = freeAfterWb(s.rt, rel, s.idx);
    full      = s.regWriteD && dst != 0 && mcnt[dst] == MAXW && !(rel && s.idx == dst);
    e.stall   = s.issueValid && !s.flush &&
                ((s.useRs && !e.rsReady) || (s.useRt && !e.rtReady) || full);
    e.err     = merr;
    e.busy    = '0;
    for (int i = 0; i < NREG; i++) e.busy[i] = (mcnt[i] != 0);
    expQ.push_back(e);

    if (s.rstLow) begin
      #1 reset = 1'b0;
    end else begin
      res = s.issueValid && !e.stall && !s.flush && s.regWriteD && dst != 0;
      if (s.regWriteW && s.idx != 0 && mcnt[s.idx] == 0 && mfmask == 0) merr = 1'b1;
      if (s.flush) begin
        foreach (mcnt[i]) mcnt[i] = 0;
        mfmask = FMASK;
      end else begin
        if (res) mcnt[dst]++;
        if (rel) mcnt[s.idx]--;
        if (mfmask > 0) mfmask--;
      end
    end
  endtask

  // Monitor: compare mid-cycle, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("stall",         32'(stall),         32'(e.stall));
        check("rs_ready",      32'(rs_ready),      32'(e.rsReady));
        check("rt_ready",      32'(rt_ready),      32'(e.rtReady));
        check("busy_vec",      busy_vec,           e.busy);
        check("err_underflow", 32'(err_underflow), 32'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    int    live [$];

    // 1: reserve r3, stalled reader of r3, released by same-cycle WB.
    s = nop(); s.rstLow = 1'b1; cyc(s); cyc(s);
    s = nop(); s.issueValid = 1; s.regWriteD = 1; s.regDstD = 1; s.rd = 3; cyc(s);
    s = nop(); s.issueValid = 1; s.useRs = 1; s.rs = 3; cyc(s); cyc(s); cyc(s);
    s.regWriteW = 1; s.idx = 3; cyc(s);
    cyc(nop());

    // 2: saturate r4 with three writers, fourth stalls until a WB frees one.
    s = nop(); s.issueValid = 1; s.regWriteD = 1; s.regDstD = 0; s.rt = 4;
    cyc(s); cyc(s); cyc(s); cyc(s);
    s.regWriteW = 1; s.idx = 4; cyc(s);
    s = nop(); s.regWriteW = 1; s.idx = 4; cyc(s);
    cyc(nop());

    // 3: r7 reserve and release in the same cycle leaves the count unchanged.
    s = nop(); s.issueValid = 1; s.regWriteD = 1; s.regDstD = 1; s.rd = 7; cyc(s);
    s.regWriteW = 1; s.idx = 7; cyc(s);
    cyc(nop());

    // 4: register 0 is never reserved and never blocks a read.
    s = nop(); s.rstLow = 1'b1; cyc(s);
    s = nop(); s.issueValid = 1; s.regWriteD = 1; s.regDstD = 1; s.rd = 0;
    s.useRs = 1; s.useRt = 1; cyc(s); cyc(s);
    s.regWriteW = 1; s.idx = 0; cyc(s);
    cyc(nop());

    // 5: underflow is sticky until reset; masked shortly after a flush.
    s = nop(); s.regWriteW = 1; s.idx = 9; cyc(s);
    cyc(nop()); cyc(nop());
    s = nop(); s.rstLow = 1'b1; cyc(s);
    s = nop(); s.issueValid = 1; s.regWriteD = 1; s.regDstD = 1; s.rd = 2; cyc(s);
    s = nop(); s.flush = 1; cyc(s);
    cyc(nop());
    s = nop(); s.regWriteW = 1; s.idx = 2; cyc(s);
    cyc(nop());
    s = nop(); s.regWriteW = 1; s.idx = 2; cyc(s);
    cyc(nop());

    // 6: asynchronous reset mid-stream while r8 is being reserved.
    s = nop(); s.rstLow = 1'b1; cyc(s);
    s = nop(); s.issueValid = 1; s.regWriteD = 1; s.regDstD = 1; s.rd = 5; cyc(s);
    s.rd = 6; cyc(s);
    s.rd = 8; s.rstLow = 1'b1; cyc(s);
    s = nop(); s.issueValid = 1; s.useRs = 1; s.useRt = 1; s.rs = 5; s.rt = 6; cyc(s);
    s.rs = 8; s.rt = 8; cyc(s);

    // Random traffic over a small register window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      s = nop();
      s.rstLow     = ($urandom_range(0, 299) == 0);
      s.issueValid = ($urandom_range(0, 3) != 0);
      s.rs         = $urandom_range(0, 7);
      s.rt         = $urandom_range(0, 7);
      s.useRs      = $urandom_range(0, 1);
      s.useRt      = $urandom_range(0, 1);
      s.regWriteD  = ($urandom_range(0, 2) != 0);
      s.regDstD    = $urandom_range(0, 1);
      s.rd         = $urandom_range(0, 7);
      s.flush      = ($urandom_range(0, 39) == 0);
      s.regWriteW  = ($urandom_range(0, 1) == 1);
      live.delete();
      for (int r = 1; r < NREG; r++) if (mcnt[r] > 0) live.push_back(r);
      if (live.size() != 0 && $urandom_range(0, 9) < 8)
        s.idx = live[$urandom_range(0, live.size() - 1)];
      else
        s.idx = $urandom_range(0, 7);
      cyc(s);
    end

    cyc(nop());
    @(negedge clk);
    #5;
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
